// File: rtl/fifo_rd_packer.sv
// Packs LANES FIFO bytes little-endian into words; a word appears the cycle after its last byte's fifo_valid.
// Reads are throttled by credit (packer depth vs 2-entry buffer) so out_ready stalls never drop bytes; `FIFO_RD_FLUSH_EN adds flush/out_keep.
module fifo_rd_packer #(
   parameter int LANES     = 4,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 rd_clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 fifo_empty,
   input  logic                 fifo_valid,
   input  logic [7:0]           fifo_rdata,
   output logic                 fifo_rd,
   output logic [8*LANES-1:0]   out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
`ifdef FIFO_RD_FLUSH_EN
   output logic [LANES-1:0]     out_keep,
   input  logic                 flush,
`endif
   output logic                 proto_err,
   output logic [CNT_WIDTH-1:0] words_out
);

   localparam int BCW = $clog2(LANES);
   localparam int W   = 8 * LANES;
   localparam int PW  = 8 * (LANES - 1);
`ifdef FIFO_RD_FLUSH_EN
   localparam int EW  = W + LANES;
`else
   localparam int EW  = W;
`endif
   localparam logic [BCW-1:0] LAST_LANE = BCW'(LANES - 1);
   localparam logic [BCW:0]   LAST_P    = (BCW+1)'(LANES - 1);

   logic [BCW-1:0]       byte_cnt_q, byte_cnt_d;
   logic [PW-1:0]        pack_q, pack_d;
   logic                 inflight_q, inflight_d;
   logic                 first_q, first_d;
   logic                 proto_err_q, proto_err_d;
   logic [1:0]           occ_q, occ_d;
   logic [EW-1:0]        buf0_q, buf0_d, buf1_q, buf1_d;
   logic [CNT_WIDTH-1:0] words_q, words_d;

   logic                 flush_pend;
   logic [BCW:0]         p_cnt;
   logic                 cap, push, pop;
   logic [W-1:0]         push_word;
   logic [EW-1:0]        push_ent;

`ifdef FIFO_RD_FLUSH_EN
   logic                 flush_pend_q, flush_pend_d;
   logic [LANES-1:0]     push_keep;

   assign flush_pend = flush_pend_q;
   assign out_keep   = buf0_q[EW-1:W];
   assign push_ent   = {push_keep, push_word};
`else
   assign flush_pend = 1'b0;
   assign push_ent   = push_word;
`endif

   assign out_data  = buf0_q[W-1:0];
   assign out_valid = (occ_q != 2'd0);
   assign proto_err = proto_err_q;
   assign words_out = words_q;

   // Block only when the bytes already committed would complete a word with no buffer slot left.
   always_comb begin
      p_cnt   = {1'b0, byte_cnt_q} + {{BCW{1'b0}}, inflight_q};
      fifo_rd = enable && !fifo_empty && !first_q && !flush_pend
                && !(p_cnt == LAST_P && occ_q == 2'd2);
   end

   always_comb begin
      byte_cnt_d  = byte_cnt_q;
      pack_d      = pack_q;
      inflight_d  = fifo_rd;
      first_d     = 1'b0;
      proto_err_d = proto_err_q;
      push        = 1'b0;
      push_word   = {fifo_rdata, pack_q};
`ifdef FIFO_RD_FLUSH_EN
      push_keep    = '1;
      flush_pend_d = flush_pend_q | flush;
`endif
      cap = fifo_valid && !first_q;

      if (cap && !inflight_q) begin
         proto_err_d = 1'b1;
      end else if (cap) begin
         if (byte_cnt_q == LAST_LANE) begin
            push       = 1'b1;
            byte_cnt_d = '0;
         end else begin
            pack_d[8*byte_cnt_q +: 8] = fifo_rdata;
            byte_cnt_d                = byte_cnt_q + BCW'(1);
         end
      end
`ifdef FIFO_RD_FLUSH_EN
      else if (flush_pend_q && !inflight_q && occ_q != 2'd2) begin
         flush_pend_d = flush;
         if (byte_cnt_q != '0) begin
            push       = 1'b1;
            byte_cnt_d = '0;
            for (int i = 0; i < LANES; i++) begin
               push_keep[i]        = (BCW'(i) < byte_cnt_q);
               push_word[8*i +: 8] = push_keep[i] ? push_word[8*i +: 8] : 8'h00;
            end
         end
      end
`endif
   end

   // Two-entry buffer: buf0 is always the head, so out_data is a plain register.
   always_comb begin
      pop     = out_valid && out_ready;
      buf0_d  = buf0_q;
      buf1_d  = buf1_q;
      occ_d   = occ_q;
      words_d = words_q;
      if (pop) begin
         words_d = words_q + CNT_WIDTH'(1);
      end
      case ({push, pop})
         2'b10: begin
            if (occ_q == 2'd0) begin
               buf0_d = push_ent;
            end else begin
               buf1_d = push_ent;
            end
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            buf0_d = buf1_q;
            occ_d  = occ_q - 2'd1;
         end
         2'b11: begin
            if (occ_q == 2'd1) begin
               buf0_d = push_ent;
            end else begin
               buf0_d = buf1_q;
               buf1_d = push_ent;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge rd_clk) begin
      if (rst) begin
         byte_cnt_q   <= '0;
         pack_q       <= '0;
         inflight_q   <= 1'b0;
         first_q      <= 1'b1;
         proto_err_q  <= 1'b0;
         occ_q        <= 2'd0;
         buf0_q       <= '0;
         buf1_q       <= '0;
         words_q      <= '0;
`ifdef FIFO_RD_FLUSH_EN
         flush_pend_q <= 1'b0;
`endif
      end else begin
         byte_cnt_q   <= byte_cnt_d;
         pack_q       <= pack_d;
         inflight_q   <= inflight_d;
         first_q      <= first_d;
         proto_err_q  <= proto_err_d;
         occ_q        <= occ_d;
         buf0_q       <= buf0_d;
         buf1_q       <= buf1_d;
         words_q      <= words_d;
`ifdef FIFO_RD_FLUSH_EN
         flush_pend_q <= flush_pend_d;
`endif
      end
   end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: a behavioural 1-cycle-latency FIFO feeds the DUT, a monitor collects accepted words.
module tb_fifo_rd_packer;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, enable, out_ready;
   logic        fifo_empty = 1'b1;
   logic        fifo_valid, fifo_rd, out_valid, proto_err;
   logic [7:0]  fifo_rdata;
   logic [31:0] out_data;
   logic [15:0] words_out;
`ifdef FIFO_RD_FLUSH_EN
   logic [3:0]  out_keep;
   logic        flush;
   logic [3:0]  rxk[$];
`endif

   logic        mdl_valid = 1'b0;
   logic [7:0]  mdl_rdata = 8'h00;
   logic        inj_valid = 1'b0;
   logic [7:0]  inj_rdata = 8'h00;
   logic        acc;
   logic [7:0]  fq[$];
   logic [31:0] rx[$];
   int          checks = 0;
   int          failures = 0;

   assign fifo_valid = mdl_valid | inj_valid;
   assign fifo_rdata = inj_valid ? inj_rdata : mdl_rdata;

   fifo_rd_packer #(.LANES(4), .CNT_WIDTH(16)) dut (
      .rd_clk     (clk),
      .rst        (rst),
      .enable     (enable),
      .fifo_empty (fifo_empty),
      .fifo_valid (fifo_valid),
      .fifo_rdata (fifo_rdata),
      .fifo_rd    (fifo_rd),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
`ifdef FIFO_RD_FLUSH_EN
      .out_keep   (out_keep),
      .flush      (flush),
`endif
      .proto_err  (proto_err),
      .words_out  (words_out)
   );

   // FIFO with read latency 1: accept at an edge, present data just after it.
   always @(posedge clk) begin
      acc = fifo_rd && !fifo_empty;
      #1;
      if (acc && fq.size() > 0) begin
         mdl_rdata = fq.pop_front();
         mdl_valid = 1'b1;
      end else begin
         mdl_valid = 1'b0;
      end
      fifo_empty = (fq.size() == 0);
   end

   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         rx.push_back(out_data);
`ifdef FIFO_RD_FLUSH_EN
         rxk.push_back(out_keep);
`endif
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   function automatic logic [63:0] rx_at(input int i);
      return (i < rx.size()) ? {32'h0, rx[i]} : 64'hDEAD_DEAD_DEAD_DEAD;
   endfunction

   initial begin
      int vcnt, v4, ov, nrd, frd, lrd;
      rst = 1'b1; enable = 1'b0; out_ready = 1'b0;
`ifdef FIFO_RD_FLUSH_EN
      flush = 1'b0;
`endif
      tick(3);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_fifo_rd", fifo_rd, 0);
      check("rst_proto_err", proto_err, 0);
      check("rst_words_out", words_out, 0);
`ifdef FIFO_RD_FLUSH_EN
      check("rst_out_keep", out_keep, 0);
`endif

      // stray fifo_valid in the first cycle after reset must be ignored
      rst = 1'b0; inj_valid = 1'b1; inj_rdata = 8'hEE;
      tick(1);
      inj_valid = 1'b0;
      tick(2);
      check("first_cycle_valid_ignored", proto_err, 0);

      // single word and its latency
      out_ready = 1'b1; enable = 1'b1; rx.delete();
      fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33); fq.push_back(8'h44);
      vcnt = 0; v4 = -100; ov = -1;
      for (int c = 0; c < 20; c++) begin
         tick(1);
         if (fifo_valid) begin
            vcnt++;
            if (vcnt == 4) v4 = c;
         end
         if (out_valid && ov < 0) ov = c;
      end
      check("t1_valid_to_out_latency", 64'(ov - v4), 64'd1);
      check("t1_word_count", rx.size(), 1);
      check("t1_word", rx_at(0), 64'h44332211);
      check("t1_words_out", words_out, 1);
      check("t1_out_valid_idle", out_valid, 0);

      // 12 bytes back to back
      rx.delete();
      for (int i = 1; i <= 12; i++) fq.push_back(8'(i));
      nrd = 0; frd = -1; lrd = -1;
      for (int c = 0; c < 24; c++) begin
         tick(1);
         if (fifo_rd) begin
            nrd++;
            if (frd < 0) frd = c;
            lrd = c;
         end
      end
      check("t2_rd_count", nrd, 12);
      check("t2_rd_contiguous", 64'(lrd - frd), 64'd11);
      check("t2_word_count", rx.size(), 3);
      check("t2_word0", rx_at(0), 64'h04030201);
      check("t2_word1", rx_at(1), 64'h08070605);
      check("t2_word2", rx_at(2), 64'h0C0B0A09);
      check("t2_words_out", words_out, 4);

      // backpressure: 2 buffered words + 3 packed bytes, then reads stop
      out_ready = 1'b0; rx.delete();
      for (int i = 0; i < 16; i++) fq.push_back(8'(8'h20 + i));
      tick(40);
      check("t3_out_valid", out_valid, 1);
      check("t3_head_held", out_data, 32'h23222120);
      check("t3_rd_blocked", fifo_rd, 0);
      check("t3_fifo_left", fq.size(), 5);
      check("t3_words_out_stalled", words_out, 4);
      out_ready = 1'b1;
      tick(30);
      check("t3_word_count", rx.size(), 4);
      check("t3_word0", rx_at(0), 64'h23222120);
      check("t3_word1", rx_at(1), 64'h27262524);
      check("t3_word2", rx_at(2), 64'h2B2A2928);
      check("t3_word3", rx_at(3), 64'h2F2E2D2C);
      check("t3_words_out", words_out, 8);
      check("t3_fifo_drained", fq.size(), 0);

      // protocol error: fifo_valid with no read in flight
      enable = 1'b0; inj_valid = 1'b1; inj_rdata = 8'h5A;
      tick(1);
      inj_valid = 1'b0;
      tick(1);
      check("t4_proto_err_set", proto_err, 1);
      tick(5);
      check("t4_proto_err_sticky", proto_err, 1);
      check("t4_no_word", out_valid, 0);
      rst = 1'b1;
      tick(2);
      check("t4_rst_proto_err", proto_err, 0);
      check("t4_rst_words_out", words_out, 0);
      check("t4_rst_out_valid", out_valid, 0);
      check("t4_rst_out_data", out_data, 0);
      rst = 1'b0;
      tick(2);

      // reset mid-word discards the partial bytes
      enable = 1'b1; rx.delete();
      fq.push_back(8'h91); fq.push_back(8'h92);
      tick(8);
      check("t5_partial_waits", rx.size(), 0);
      rst = 1'b1;
      fq.push_back(8'hA0); fq.push_back(8'hA1); fq.push_back(8'hA2); fq.push_back(8'hA3);
      tick(3);
      check("t5_rd_in_reset", fifo_rd, 0);
      check("t5_fifo_untouched", fq.size(), 4);
      rst = 1'b0;
      tick(15);
      check("t5_word_count", rx.size(), 1);
      check("t5_word", rx_at(0), 64'hA3A2A1A0);
      check("t5_words_out", words_out, 1);

`ifdef FIFO_RD_FLUSH_EN
      rx.delete(); rxk.delete();
      fq.push_back(8'h55); fq.push_back(8'h66);
      tick(8);
      check("t6_partial_waits", rx.size(), 0);
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      tick(6);
      check("t6_flush_count", rx.size(), 1);
      check("t6_flush_word", rx_at(0), 64'h00006655);
      check("t6_flush_keep", (rxk.size() > 0) ? rxk[0] : 4'hX, 4'b0011);
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      tick(6);
      check("t6_empty_flush", rx.size(), 1);
      for (int i = 1; i <= 4; i++) fq.push_back(8'(i));
      tick(12);
      check("t6_full_word", rx_at(1), 64'h04030201);
      check("t6_full_keep", (rxk.size() > 1) ? rxk[1] : 4'hX, 4'hF);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
